// File: rtl/mips_cpu_alu_pkg.sv
// Shared definitions for the iterative multiply/divide unit:
// op encodings, controller states and legal unroll factors.
package mips_cpu_alu_pkg;

   typedef enum logic [2:0] {
      OP_MULT  = 3'b000,
      OP_MULTU = 3'b001,
      OP_DIV   = 3'b010,
      OP_DIVU  = 3'b011,
      OP_MTHI  = 3'b100,
      OP_MTLO  = 3'b101
   } op_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PREP = 2'd1,
      ST_ITER = 2'd2,
      ST_FIX  = 2'd3
   } state_e;

   localparam int LEGAL_UNROLL [3] = '{1, 2, 4};

   function automatic bit is_legal_unroll(input int u);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (LEGAL_UNROLL[i] == u) ok = 1'b1;
      end
      return ok;
   endfunction

endpackage

// File: rtl/mips_cpu_alu_muldiv_iter_div_step.sv
// Combinational restoring-divide slice: UNROLL quotient bits per call,
// dividend bits shift out of quo_i MSB-first as quotient bits enter at LSB.
module mips_cpu_div_step #(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic [WIDTH-1:0] rem_i,
   input  logic [WIDTH-1:0] quo_i,
   input  logic [WIDTH-1:0] dvs_i,
   output logic [WIDTH-1:0] rem_o,
   output logic [WIDTH-1:0] quo_o
);

   logic [WIDTH:0] sh;
   logic [WIDTH:0] diff;

   always_comb begin
      rem_o = rem_i;
      quo_o = quo_i;
      sh    = '0;
      diff  = '0;
      for (int i = 0; i < UNROLL; i++) begin
         sh    = {rem_o, quo_o[WIDTH-1]};
         diff  = sh - {1'b0, dvs_i};
         quo_o = {quo_o[WIDTH-2:0], 1'b0};
         if (sh >= {1'b0, dvs_i}) begin
            rem_o    = diff[WIDTH-1:0];
            quo_o[0] = 1'b1;
         end else begin
            rem_o = sh[WIDTH-1:0];
         end
      end
   end

endmodule

// File: rtl/mips_cpu_alu_muldiv_iter.sv
// Iterative MULT/MULTU/DIV/DIVU unit owning HI/LO, with abort on flush.
// Define MIPS_CPU_MULDIV_FAST_MULT_EN for a single-cycle multiply path.
module mips_cpu_alu_muldiv_iter
   import mips_cpu_alu_pkg::*;
#(
   parameter int WIDTH  = 32,
   parameter int UNROLL = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             abort,
   output logic             busy,
   output logic             done,
   output logic             div_by_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int N  = WIDTH / UNROLL;
   localparam int CW = $clog2(N + 1);

   if (!is_legal_unroll(UNROLL) || (WIDTH % UNROLL) != 0 ||
       WIDTH < 8 || (WIDTH % 2) != 0) begin : g_bad_cfg
      $error("mips_cpu_alu_muldiv_iter: illegal WIDTH/UNROLL");
   end

   state_e           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
   logic             done_q, done_d, dbz_q, dbz_d;
   logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
   logic             div_q, div_d, sgn_q, sgn_d;
   logic [WIDTH-1:0] acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
   logic [WIDTH-1:0] mcd_q, mcd_d;
   logic             neg_q, neg_d, rneg_q, rneg_d, zero_q, zero_d;

   logic [WIDTH-1:0]   abs_a, abs_b;
   logic [WIDTH-1:0]   mp_hi, mp_lo;
   logic [WIDTH:0]     msum;
   logic [WIDTH-1:0]   dv_rem, dv_quo;
   logic [2*WIDTH-1:0] prod, prod_s;
   logic [WIDTH-1:0]   quo_s, rem_s;
   logic               md_req;

   assign busy        = (state_q != ST_IDLE);
   assign done        = done_q;
   assign div_by_zero = dbz_q;
   assign hi          = hi_q;
   assign lo          = lo_q;

   assign abs_a  = (sgn_q && a_q[WIDTH-1]) ? ('0 - a_q) : a_q;
   assign abs_b  = (sgn_q && b_q[WIDTH-1]) ? ('0 - b_q) : b_q;
   assign md_req = (op[2] == 1'b0);

   // Shift-add: multiplier sits in acc_lo and drains out its LSB.
   always_comb begin
      mp_hi = acc_hi_q;
      mp_lo = acc_lo_q;
      msum  = '0;
      for (int i = 0; i < UNROLL; i++) begin
         msum  = mp_lo[0] ? ({1'b0, mp_hi} + {1'b0, mcd_q})
                          : {1'b0, mp_hi};
         mp_lo = {msum[0], mp_lo[WIDTH-1:1]};
         mp_hi = msum[WIDTH:1];
      end
   end

   mips_cpu_div_step #(
      .WIDTH  (WIDTH),
      .UNROLL (UNROLL)
   ) u_div_step (
      .rem_i (acc_hi_q),
      .quo_i (acc_lo_q),
      .dvs_i (mcd_q),
      .rem_o (dv_rem),
      .quo_o (dv_quo)
   );

   always_comb begin
      prod   = {acc_hi_q, acc_lo_q};
      prod_s = neg_q ? ('0 - prod) : prod;
      quo_s  = neg_q ? ('0 - acc_lo_q) : acc_lo_q;
      rem_s  = rneg_q ? ('0 - acc_hi_q) : acc_hi_q;
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      hi_d     = hi_q;
      lo_d     = lo_q;
      done_d   = 1'b0;
      dbz_d    = 1'b0;
      a_d      = a_q;
      b_d      = b_q;
      div_d    = div_q;
      sgn_d    = sgn_q;
      acc_hi_d = acc_hi_q;
      acc_lo_d = acc_lo_q;
      mcd_d    = mcd_q;
      neg_d    = neg_q;
      rneg_d   = rneg_q;
      zero_d   = zero_q;
      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               unique case (1'b1)
                  md_req: begin
                     a_d     = a;
                     b_d     = b;
                     div_d   = op[1];
                     sgn_d   = ~op[0];
                     state_d = ST_PREP;
                  end
                  (op == OP_MTHI): hi_d = a;
                  (op == OP_MTLO): lo_d = a;
                  default: ;
               endcase
            end
         end
         ST_PREP: begin
            mcd_d    = div_q ? abs_b : abs_a;
            acc_lo_d = div_q ? abs_a : abs_b;
            acc_hi_d = '0;
            neg_d    = sgn_q & (a_q[WIDTH-1] ^ b_q[WIDTH-1]);
            rneg_d   = sgn_q & a_q[WIDTH-1];
            zero_d   = div_q & (b_q == '0);
`ifdef MIPS_CPU_MULDIV_FAST_MULT_EN
            if (!div_q) begin
               {acc_hi_d, acc_lo_d} = {{WIDTH{1'b0}}, abs_a} *
                                      {{WIDTH{1'b0}}, abs_b};
               state_d = ST_FIX;
            end else begin
               cnt_d   = CW'(N);
               state_d = ST_ITER;
            end
`else
            cnt_d   = CW'(N);
            state_d = ST_ITER;
`endif
         end
         ST_ITER: begin
            acc_hi_d = div_q ? dv_rem : mp_hi;
            acc_lo_d = div_q ? dv_quo : mp_lo;
            cnt_d    = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = ST_FIX;
         end
         ST_FIX: begin
            if (!div_q) begin
               hi_d = prod_s[2*WIDTH-1:WIDTH];
               lo_d = prod_s[WIDTH-1:0];
            end else if (zero_q) begin
               hi_d = a_q;
               lo_d = '1;
            end else begin
               hi_d = rem_s;
               lo_d = quo_s;
            end
            done_d  = 1'b1;
            dbz_d   = zero_q;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      // Flush wins over everything, including a same-cycle MTHI/MTLO.
      if (abort) begin
         state_d = ST_IDLE;
         hi_d    = hi_q;
         lo_d    = lo_q;
         done_d  = 1'b0;
         dbz_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         hi_q     <= '0;
         lo_q     <= '0;
         done_q   <= 1'b0;
         dbz_q    <= 1'b0;
         a_q      <= '0;
         b_q      <= '0;
         div_q    <= 1'b0;
         sgn_q    <= 1'b0;
         acc_hi_q <= '0;
         acc_lo_q <= '0;
         mcd_q    <= '0;
         neg_q    <= 1'b0;
         rneg_q   <= 1'b0;
         zero_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         hi_q     <= hi_d;
         lo_q     <= lo_d;
         done_q   <= done_d;
         dbz_q    <= dbz_d;
         a_q      <= a_d;
         b_q      <= b_d;
         div_q    <= div_d;
         sgn_q    <= sgn_d;
         acc_hi_q <= acc_hi_d;
         acc_lo_q <= acc_lo_d;
         mcd_q    <= mcd_d;
         neg_q    <= neg_d;
         rneg_q   <= rneg_d;
         zero_q   <= zero_d;
      end
   end

endmodule

// File: tb/tb_mips_cpu_alu_muldiv_iter.sv
// Directed bench for the iterative multiply/divide unit (default build:
// WIDTH=32, UNROLL=1, 34-edge latency).
module tb_mips_cpu_alu_muldiv_iter;
   import mips_cpu_alu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        abort = 1'b0;
   logic [2:0]  op = 3'b111;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy, done, div_by_zero;
   logic [31:0] hi, lo;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mips_cpu_alu_muldiv_iter #(.WIDTH(32), .UNROLL(1)) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .op          (op),
      .a           (a),
      .b           (b),
      .abort       (abort),
      .busy        (busy),
      .done        (done),
      .div_by_zero (div_by_zero),
      .hi          (hi),
      .lo          (lo)
   );

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic [2:0] o, input logic [31:0] x,
                        input logic [31:0] y);
      start = 1'b1;
      op    = o;
      a     = x;
      b     = y;
      tick();
      start = 1'b0;
      op    = 3'b111;
      a     = $urandom;
      b     = $urandom;
   endtask

   task automatic wait_done(output int lat);
      lat = 0;
      do begin
         tick();
         lat++;
      end while (!done && lat < 100);
   endtask

   task automatic run(input string tag, input logic [2:0] o,
                      input logic [31:0] x, input logic [31:0] y,
                      input logic [31:0] eh, input logic [31:0] el,
                      input logic ez);
      int lat;
      issue(o, x, y);
      check({tag, "_busy"}, 64'(busy), 64'd1);
      wait_done(lat);
      check({tag, "_lat"}, 64'(lat), 64'd34);
      check({tag, "_hi"}, 64'(hi), 64'(eh));
      check({tag, "_lo"}, 64'(lo), 64'(el));
      check({tag, "_dbz"}, 64'(div_by_zero), 64'(ez));
      check({tag, "_idle"}, 64'(busy), 64'd0);
      tick();
      check({tag, "_pulse"}, 64'(done), 64'd0);
   endtask

   initial begin
      int lat;
      bit seen;

      tick();
      tick();
      check("rst_hi", 64'(hi), 64'd0);
      check("rst_lo", 64'(lo), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_done", 64'(done), 64'd0);
      check("rst_dbz", 64'(div_by_zero), 64'd0);
      reset = 1'b1;
      tick();

      run("mult", OP_MULT, 32'hFFFF_FFFD, 32'd7,
          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
      run("multu", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
          32'hFFFF_FFFE, 32'h0000_0001, 1'b0);
      run("div", OP_DIV, 32'hFFFF_FFF9, 32'd2,
          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
      run("divu", OP_DIVU, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      run("divu0", OP_DIVU, 32'd7, 32'd0,
          32'd7, 32'hFFFF_FFFF, 1'b1);
      run("divovf", OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF,
          32'd0, 32'h8000_0000, 1'b0);
      run("divneg", OP_DIV, 32'd7, 32'hFFFF_FFFE,
          32'd1, 32'hFFFF_FFFD, 1'b0);
      run("multmin", OP_MULT, 32'h8000_0000, 32'h8000_0000,
          32'h4000_0000, 32'd0, 1'b0);

      start = 1'b1; op = OP_MTHI; a = 32'h11;
      tick();
      start = 1'b0; op = 3'b111;
      check("mthi11", 64'(hi), 64'h11);

      issue(OP_DIVU, 32'd100, 32'd7);
      for (int k = 1; k <= 9; k++) begin
         start = 1'b1; op = OP_MTHI; a = 32'h55;
         tick();
      end
      start = 1'b0; op = 3'b111;
      tick();
      check("abort_busy_e10", 64'(busy), 64'd1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_done", 64'(done), 64'd0);
      check("abort_hi", 64'(hi), 64'h11);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done || busy) seen = 1'b1;
      end
      check("abort_quiet", 64'(seen), 64'd0);

      start = 1'b1; abort = 1'b1; op = OP_MTLO; a = 32'h99;
      tick();
      start = 1'b0; abort = 1'b0; op = 3'b111;
      check("abort_mtlo", 64'(lo), 64'd0);

      start = 1'b1; op = OP_MTHI; a = 32'h1234_5678;
      tick();
      start = 1'b0; op = 3'b111;
      check("mthi_hi", 64'(hi), 64'h1234_5678);
      check("mthi_busy", 64'(busy), 64'd0);
      tick();
      check("mthi_done", 64'(done), 64'd0);

      issue(OP_MULTU, 32'd3, 32'd5);
      wait_done(lat);
      check("b2b1_lat", 64'(lat), 64'd34);
      check("b2b1_lo", 64'(lo), 64'd15);
      start = 1'b1; op = OP_MULTU; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
      tick();
      start = 1'b0; op = 3'b111; a = $urandom; b = $urandom;
      check("b2b2_busy", 64'(busy), 64'd1);
      wait_done(lat);
      check("b2b2_lat", 64'(lat), 64'd34);
      check("b2b2_hi", 64'(hi), 64'hFFFF_FFFE);
      check("b2b2_lo", 64'(lo), 64'h0000_0001);

      issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
      repeat (5) tick();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      check("mrst_hi", 64'(hi), 64'd0);
      check("mrst_lo", 64'(lo), 64'd0);
      check("mrst_busy", 64'(busy), 64'd0);
      check("mrst_done", 64'(done), 64'd0);
      check("mrst_dbz", 64'(div_by_zero), 64'd0);
      seen = 1'b0;
      repeat (40) begin
         tick();
         if (done) seen = 1'b1;
      end
      check("mrst_quiet", 64'(seen), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
